// File: rtl/seg7_hex_reader.sv
`default_nettype none
// ============================================================================
// Module      : seg7_hex_reader
// Description : Deserialises seven-segment patterns (a..g, one bit per valid
//               cycle) and recovers the hex digit once the pattern is stable.
// Revision    : 1.0  initial release
// ============================================================================
module seg7_hex_reader #(
    parameter int STABLE_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seg_bit,
    input  logic       seg_valid,
    input  logic       frame_start,
    output logic [3:0] out_hex,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_err,
    output logic       out_ovf
);

    localparam logic [3:0] c_stable_frames = 4'(STABLE_FRAMES);
    localparam logic [2:0] c_last_bit      = 3'd6;

    // Collection stage
    logic [5:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_dec_frame;
    logic       r_dec_vld;

    // Stability and output stage
    logic [6:0] r_last;
    logic [3:0] r_stab;
    logic [3:0] r_hex;
    logic       r_valid;
    logic       r_err;
    logic       r_ovf;

    logic [4:0] w_lookup;
    logic       w_legal;
    logic [3:0] w_digit;
    logic       w_same;
    logic [3:0] w_stab_next;
    logic       w_issue;

    // Returns {legal, digit}; frame layout is {a,b,c,d,e,f,g} with a as MSB.
    function automatic logic [4:0] font_lookup(input logic [6:0] pat);
        logic [4:0] res;
        res = 5'b0_0000;
        case (pat)
            7'b1111110: res = {1'b1, 4'h0};
            7'b0110000: res = {1'b1, 4'h1};
            7'b1101101: res = {1'b1, 4'h2};
            7'b1111001: res = {1'b1, 4'h3};
            7'b0110011: res = {1'b1, 4'h4};
            7'b1011011: res = {1'b1, 4'h5};
            7'b1011111: res = {1'b1, 4'h6};
            7'b1110000: res = {1'b1, 4'h7};
            7'b1111111: res = {1'b1, 4'h8};
            7'b1110011: res = {1'b1, 4'h9};
            7'b1110111: res = {1'b1, 4'hA};
            7'b0011111: res = {1'b1, 4'hB};
            7'b1001110: res = {1'b1, 4'hC};
            7'b0111101: res = {1'b1, 4'hD};
            7'b1001111: res = {1'b1, 4'hE};
            7'b1000111: res = {1'b1, 4'hF};
            default:    res = 5'b0_0000;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_dec_frame <= '0;
            r_dec_vld   <= 1'b0;
        end else begin
            r_dec_vld <= 1'b0;
            if (seg_valid) begin
                if (frame_start) begin
                    r_shift   <= {5'b0, seg_bit};
                    r_bit_cnt <= 3'd1;
                end else if (r_bit_cnt == c_last_bit) begin
                    r_dec_frame <= {r_shift, seg_bit};
                    r_dec_vld   <= 1'b1;
                    r_shift     <= '0;
                    r_bit_cnt   <= '0;
                end else begin
                    r_shift   <= {r_shift[4:0], seg_bit};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end
        end
    end

    // The cleared last pattern (all zeros) is never a legal glyph, so no
    // separate "last valid" flag is required.
    always_comb begin
        w_lookup    = font_lookup(r_dec_frame);
        w_legal     = w_lookup[4];
        w_digit     = w_lookup[3:0];
        w_same      = (r_dec_frame == r_last);
        w_stab_next = 4'd0;
        if (w_legal) begin
            if (!w_same) begin
                w_stab_next = 4'd1;
            end else if (r_stab >= c_stable_frames) begin
                w_stab_next = c_stable_frames;
            end else begin
                w_stab_next = r_stab + 4'd1;
            end
        end
        w_issue = r_dec_vld && w_legal && (w_stab_next == c_stable_frames)
                  && !(w_same && (r_stab == c_stable_frames));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last  <= '0;
            r_stab  <= '0;
            r_hex   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (r_dec_vld) begin
                r_stab <= w_stab_next;
                if (w_legal) begin
                    r_last <= r_dec_frame;
                end else begin
                    r_last <= '0;
                    r_err  <= 1'b1;
                end
            end

            if (w_issue) begin
                if (!r_valid || out_ready) begin
                    r_hex   <= w_digit;
                    r_valid <= 1'b1;
                end else begin
                    r_ovf <= 1'b1;
                end
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_hex   = r_hex;
    assign out_valid = r_valid;
    assign out_err   = r_err;
    assign out_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seg7_hex_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_hex_reader
// Description : Directed self-checking bench for seg7_hex_reader.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_hex_reader;

    logic       clk;
    logic       rst;
    logic       seg_bit;
    logic       seg_valid;
    logic       frame_start;
    logic       out_ready;

    logic [3:0] hex2, hex1;
    logic       vld2, vld1;
    logic       err2, err1;
    logic       ovf2, ovf1;

    int         checks;
    int         errors;
    int         err_pulses;
    logic [3:0] q2[$];
    logic [3:0] q1[$];

    logic [6:0] font [16];

    seg7_hex_reader #(.STABLE_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .seg_bit(seg_bit), .seg_valid(seg_valid),
        .frame_start(frame_start), .out_hex(hex2), .out_valid(vld2),
        .out_ready(out_ready), .out_err(err2), .out_ovf(ovf2)
    );

    seg7_hex_reader #(.STABLE_FRAMES(1)) dut1 (
        .clk(clk), .rst(rst), .seg_bit(seg_bit), .seg_valid(seg_valid),
        .frame_start(frame_start), .out_hex(hex1), .out_valid(vld1),
        .out_ready(out_ready), .out_err(err1), .out_ovf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted transfer and every error pulse.
    always @(negedge clk) begin
        if (vld2 && out_ready) q2.push_back(hex2);
        if (vld1 && out_ready) q1.push_back(hex1);
        if (err2) err_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic fs);
        seg_bit     = b;
        frame_start = fs;
        seg_valid   = 1'b1;
        tick();
        seg_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_frame(input logic [6:0] p);
        for (int i = 0; i < 7; i++) begin
            seg_bit     = p[6-i];
            frame_start = (i == 0);
            seg_valid   = 1'b1;
            tick();
        end
        seg_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        tick();
    endtask

    int base;
    int ebase;

    initial begin
        checks = 0; errors = 0; err_pulses = 0;
        font[0]  = 7'b1111110; font[1]  = 7'b0110000; font[2]  = 7'b1101101;
        font[3]  = 7'b1111001; font[4]  = 7'b0110011; font[5]  = 7'b1011011;
        font[6]  = 7'b1011111; font[7]  = 7'b1110000; font[8]  = 7'b1111111;
        font[9]  = 7'b1110011; font[10] = 7'b1110111; font[11] = 7'b0011111;
        font[12] = 7'b1001110; font[13] = 7'b0111101; font[14] = 7'b1001111;
        font[15] = 7'b1000111;
        seg_bit = 0; seg_valid = 0; frame_start = 0; out_ready = 1; rst = 0;

        do_reset();
        check("reset_valid", vld2, 0);
        check("reset_hex", hex2, 0);
        check("reset_err", err2, 0);
        check("reset_ovf", ovf2, 0);

        // Digit 5: one frame is not enough, the second issues, third is silent
        base = q2.size();
        send_frame(7'b1011011);
        idle(3);
        check("one_frame_no_out", q2.size() - base, 0);
        send_frame(7'b1011011);
        check("latency_not_early", vld2, 0);
        tick();
        check("latency_valid", vld2, 1);
        check("latency_hex", hex2, 4'h5);
        idle(3);
        send_frame(7'b1011011);
        idle(4);
        check("no_reissue", q2.size() - base, 1);

        // Back-to-back 0,0,1,1 with no idle cycles
        base = q2.size();
        send_frame(font[0]); send_frame(font[0]);
        send_frame(font[1]); send_frame(font[1]);
        idle(4);
        check("b2b_count", q2.size() - base, 2);
        if (q2.size() - base == 2) begin
            check("b2b_first", q2[base], 4'h0);
            check("b2b_second", q2[base+1], 4'h1);
        end

        // Illegal frame then 9
        ebase = err_pulses;
        send_frame(7'b0000001);
        check("err_not_early", err2, 0);
        tick();
        check("err_pulse", err2, 1);
        tick();
        check("err_one_cycle", err2, 0);
        check("err_count", err_pulses - ebase, 1);
        base = q2.size();
        send_frame(font[9]); send_frame(font[9]);
        idle(4);
        check("after_err_count", q2.size() - base, 1);
        if (q2.size() > base) check("after_err_hex", q2[base], 4'h9);

        // Partial frame abandoned by frame_start
        ebase = err_pulses;
        base = q2.size();
        send_bit(1, 1); send_bit(0, 0); send_bit(1, 0); send_bit(1, 0);
        send_frame(font[15]); send_frame(font[15]);
        idle(4);
        check("resync_count", q2.size() - base, 1);
        if (q2.size() > base) check("resync_hex", q2[base], 4'hF);
        check("resync_no_err", err_pulses - ebase, 0);

        // Backpressure and overflow
        out_ready = 0;
        base = q2.size();
        send_frame(font[10]); send_frame(font[10]);
        idle(3);
        check("bp_valid", vld2, 1);
        check("bp_hex_a", hex2, 4'hA);
        check("bp_no_ovf", ovf2, 0);
        send_frame(font[13]); send_frame(font[13]);
        idle(3);
        check("ovf_hex_kept", hex2, 4'hA);
        check("ovf_set", ovf2, 1);
        out_ready = 1;
        idle(4);
        check("ovf_one_xfer", q2.size() - base, 1);
        if (q2.size() > base) check("ovf_xfer_hex", q2[base], 4'hA);
        check("ovf_valid_drop", vld2, 0);
        check("ovf_sticky", ovf2, 1);
        do_reset();
        check("ovf_cleared", ovf2, 0);

        // Reset mid-frame discards partial bits without an error
        ebase = err_pulses;
        send_bit(1, 1); send_bit(1, 0); send_bit(0, 0);
        do_reset();
        send_bit(1, 0); send_bit(1, 0); send_bit(1, 0); send_bit(1, 0);
        idle(3);
        check("rst_mid_no_err", err_pulses - ebase, 0);

        // Sweep every digit through the STABLE_FRAMES=1 instance
        do_reset();
        for (int d = 0; d < 16; d++) begin
            base = q1.size();
            send_frame(font[d]);
            idle(3);
            check($sformatf("sweep_cnt_%0d", d), q1.size() - base, 1);
            if (q1.size() > base) check($sformatf("sweep_hex_%0d", d), q1[base], d[3:0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
